mem_sram_ctrl: RTL

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

---
 rtl/mem_sram_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller that splits each 32-bit load/store into two 16-bit
// SRAM phases (low then high half-word) and freezes the pipeline meanwhile.
module mem_sram_ctrl #(
    parameter int unsigned SRAM_WAIT = 2,          // cycles per half-word phase, 1..7
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned HW_AW  = 18;
    localparam int unsigned WIDX_W = 17;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [HW_AW-1:0]  sram_addr_q, sram_addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              we_n_q, we_n_d;
    logic [WIDX_W-1:0] word_idx;

    // Stall whenever a request is present, except in the single DONE cycle.
    assign ready = ~((rd_en | wr_en) & (state_q != ST_DONE));

    assign read_data   = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

    // Sequencing: latch the op in IDLE, then LO and HI phases of SRAM_WAIT cycles each.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_en | wr_en) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    wr_d    = wr_en;
                    addr_d  = address;
                    data_d  = write_data;
                end
            end
            ST_LO: begin
                if (cnt_q == CNT_LAST) begin
                    if (!wr_q) rdata_d[15:0] = sram_dq_in;
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HI: begin
                if (cnt_q == CNT_LAST) begin
                    if (!wr_q) rdata_d[31:16] = sram_dq_in;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // SRAM pins are decoded from the next state so they line up with the phase itself.
    always_comb begin
        sram_addr_d = '0;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        word_idx    = WIDX_W'((addr_d - BASE_ADDR) >> 2);
        if (state_d == ST_LO || state_d == ST_HI) begin
            sram_addr_d = {word_idx, (state_d == ST_HI)};
            if (wr_d) begin
                we_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                dq_out_d = (state_d == ST_HI) ? data_d[31:16] : data_d[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

endmodule
